iddmm_feeder: RTL and testbench
===============================

Name: iddmm_feeder

Overview:
- Sequencing stage directly upstream and downstream of the iddmm_top Montgomery multiplier.
- Accepts operand words x, y and m over a valid/ready stream. Writes them into the multiplier RAMs via wr_ena/wr_addr/wr_x/wr_y/wr_m, then issues task_req.
- Captures the N result words from task_res into an internal buffer and replays them on a valid/ready output stream.
- The multiplier cannot be stalled, so all back-pressure is absorbed here.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand.
- ADDR_W, $clog2(N), word address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m1_in  in  K  Montgomery constant -m^-1 mod 2^K; sampled at the first accepted x word.
- in_valid  in  1  operand word valid.
- in_ready  out  1  operand word accepted when in_valid & in_ready.
- in_data  in  K  operand word, LSW first; order is x[0..N-1], y[0..N-1], m[0..N-1].
- wr_ena  out  3  one-hot RAM write enable: bit0 = x, bit1 = y, bit2 = m.
- wr_addr  out  ADDR_W  RAM word address.
- wr_x  out  K  write data to the x RAM.
- wr_y  out  K  write data to the y RAM.
- wr_m  out  K  write data to the m RAM.
- wr_m1  out  K  registered m1.
- task_req  out  1  multiplication request.
- task_grant  in  1  multiplier accepted the request.
- task_end  in  1  one cycle per valid result word.
- task_res  in  K  result word, LSW first.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_data  out  K  result word.
- out_last  out  1  marks word N-1 of a result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs 0. State is IDLE, all counters are 0, the buffer is empty.
- States: IDLE, LOAD_X, LOAD_Y, LOAD_M, REQ, RUN, DRAIN.
- IDLE:
  - in_ready = 1.
  - The first accepted word is x[0]; m1_in is latched at that beat.
  - Next state is LOAD_X with word count 1. If N = 1, go straight to LOAD_Y.
- LOAD_X / LOAD_Y / LOAD_M:
  - in_ready = 1.
  - Every accepted beat drives wr_ena bit, wr_addr and wr_* registered one cycle later; wr_* and wr_addr hold their last value otherwise.
  - The word counter wraps N-1 -> 0 and advances the state: X -> Y -> M -> REQ.
  - The write for the final m word lands in the cycle the state enters REQ.
- REQ:
  - in_ready = 0. task_req is held high until task_grant is sampled high.
  - Then task_req drops in the next cycle and the state moves to RUN.
  - A grant seen before the final RAM write has completed is ignored (this cannot happen by construction).
- RUN:
  - On every task_end, task_res is written into buffer slot rcnt and rcnt increments.
  - When rcnt reaches N, the state moves to DRAIN. Writes happen regardless of out_ready.
- DRAIN:
  - out_data is the buffer word at rptr; out_valid = 1.
  - rptr advances on out_valid & out_ready. out_last = (rptr == N-1).
  - The accepting beat with out_last returns the state to IDLE. The first output word is available 1 cycle after entering DRAIN (registered buffer read).
- Output overlap is not allowed; the next operand load begins only after the drain completes.
- task_end outside RUN is ignored, and an "unexpected task_end" sticky flag is set (visible only in simulation assertions).
- Reset mid-operation: returns immediately to IDLE, empties the buffer and drops task_req. The multiplier is reset by the same rst_n.
- Buffer: N x K, single write port and single read port, no full/empty flags. Occupancy is fully determined by the state machine.

Optional Feature:
- Macro IDDMM_FEEDER_REUSE_M_EN.
- Defined:
  - An extra input reuse_m (1 bit) is sampled with x[0].
  - When reuse_m = 1 and an m has been loaded since reset, LOAD_M is skipped: LOAD_Y goes directly to REQ and the m RAM and m1 are left unchanged.
  - When reuse_m = 1 and no m has been loaded yet, the flag is ignored and m is loaded.
- Undefined: the port is absent and m is loaded for every task.

Decomposition:
- Package iddmm_pkg:
  - state enum feeder_state_t;
  - localparams for the wr_ena bit positions WR_X = 0, WR_Y = 1, WR_M = 2;
  - the default K and N.
- One sub-module: iddmm_res_buf, the N x K buffer with registered read, mirroring the existing dual_port_ram style.

Test Plan:
- Basic task, K = 8, N = 4: stream x = {1,2,3,4}, y = {5,6,7,8}, m = {9,10,11,12}.
  - Expect wr_ena = 001/010/100 with wr_addr 0..3 each.
  - Expect task_req asserted in the cycle after the last m write and held until a grant injected 5 cycles later.
- Result capture under back-pressure: model task_end for 4 cycles with task_res = {A0,A1,A2,A3} while out_ready = 0.
  - Expect out_valid 1 cycle after RUN ends, out_data = A0.
  - Toggle out_ready 1010: expect A0..A3 in order, out_last only on A3, then state IDLE.
- Input stalls: in_valid random at 30% duty during load.
  - Expect addresses to remain contiguous and exactly 12 writes.
  - Expect in_ready = 0 during REQ/RUN/DRAIN.
- Reset mid-RUN: assert rst_n low after 2 of 4 task_end words.
  - Expect all outputs 0 and busy = 0.
  - A fresh task afterwards must produce only the new result words.
- Stray task_end while IDLE: expect no buffer write, out_valid stays 0, and the assertion flag fires.
- IDDMM_FEEDER_REUSE_M_EN: run the first task with reuse_m = 1, so m is loaded anyway. Run the second task with reuse_m = 1 and only 8 input words.
  - Expect no wr_ena[2] in the second task and task_req right after y[3].

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared types and constants for the iddmm operand/result feeder.
// Holds the FSM state encoding, the RAM write-enable bit positions and the default geometry.
package iddmm_pkg;

    localparam int K_DEF = 128;
    localparam int N_DEF = 32;

    localparam int WR_X = 0;
    localparam int WR_Y = 1;
    localparam int WR_M = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_Y = 3'd2,
        ST_LOAD_M = 3'd3,
        ST_REQ    = 3'd4,
        ST_RUN    = 3'd5,
        ST_DRAIN  = 3'd6
    } feeder_state_t;

endpackage

// File: rtl/iddmm_res_buf.sv
// N x K result buffer: one write port, one registered read port (1-cycle read latency).
// No flow control of its own; occupancy is owned by the feeder FSM.
module iddmm_res_buf #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [K-1:0]      wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [K-1:0]      rd_data_o
);

    logic [K-1:0] mem [N];
    logic [K-1:0] rd_data_q;

    // Array left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/iddmm_feeder.sv
// Loads x/y/m into the iddmm multiplier RAMs, requests a task, buffers the N result words and replays them
// on a valid/ready stream (first word 1 cycle after DRAIN entry); all back-pressure absorbed here. Option: IDDMM_FEEDER_REUSE_M_EN.
module iddmm_feeder
    import iddmm_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int N      = N_DEF,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [K-1:0]      m1_in,
`ifdef IDDMM_FEEDER_REUSE_M_EN
    input  logic              reuse_m,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K-1:0]      in_data,
    output logic [2:0]        wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_x,
    output logic [K-1:0]      wr_y,
    output logic [K-1:0]      wr_m,
    output logic [K-1:0]      wr_m1,
    output logic              task_req,
    input  logic              task_grant,
    input  logic              task_end,
    input  logic [K-1:0]      task_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [K-1:0]      out_data,
    output logic              out_last,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    feeder_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [2:0]        wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [K-1:0]      wr_x_q, wr_x_d, wr_y_q, wr_y_d, wr_m_q, wr_m_d, wr_m1_q, wr_m1_d;
    logic              task_req_q, task_req_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              unexp_end_q, unexp_end_d;
    logic              in_fire, cnt_last, skip_m, buf_we, buf_re;
    logic [K-1:0]      buf_rd_data;

`ifdef IDDMM_FEEDER_REUSE_M_EN
    logic m_loaded_q, m_loaded_d;
    logic reuse_q, reuse_d;
    assign skip_m = reuse_q & m_loaded_q;
`else
    assign skip_m = 1'b0;
`endif

    assign in_fire  = in_valid & in_ready_q;
    assign cnt_last = (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        rptr_d      = rptr_q;
        wr_ena_d    = 3'b000;
        wr_addr_d   = wr_addr_q;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        wr_m_d      = wr_m_q;
        wr_m1_d     = wr_m1_q;
        task_req_d  = 1'b0;
        out_valid_d = 1'b0;
        buf_we      = 1'b0;
`ifdef IDDMM_FEEDER_REUSE_M_EN
        m_loaded_d  = m_loaded_q;
        reuse_d     = reuse_q;
`endif
        case (state_q)
            // IDLE accepts x[0] with cnt_q == 0, so it shares the x-load path.
            ST_IDLE, ST_LOAD_X: begin
                if (in_fire) begin
                    wr_ena_d[WR_X] = 1'b1;
                    wr_addr_d      = cnt_q;
                    wr_x_d         = in_data;
                    if (state_q == ST_IDLE) begin
`ifdef IDDMM_FEEDER_REUSE_M_EN
                        reuse_d = reuse_m;
                        if (!(reuse_m && m_loaded_q)) begin
                            wr_m1_d = m1_in;
                        end
`else
                        wr_m1_d = m1_in;
`endif
                    end
                    cnt_d   = cnt_last ? '0 : cnt_q + ADDR_W'(1);
                    state_d = cnt_last ? ST_LOAD_Y : ST_LOAD_X;
                end
            end
            ST_LOAD_Y: begin
                if (in_fire) begin
                    wr_ena_d[WR_Y] = 1'b1;
                    wr_addr_d      = cnt_q;
                    wr_y_d         = in_data;
                    cnt_d          = cnt_last ? '0 : cnt_q + ADDR_W'(1);
                    if (cnt_last) begin
                        state_d = skip_m ? ST_REQ : ST_LOAD_M;
                    end
                end
            end
            ST_LOAD_M: begin
                if (in_fire) begin
                    wr_ena_d[WR_M] = 1'b1;
                    wr_addr_d      = cnt_q;
                    wr_m_d         = in_data;
                    cnt_d          = cnt_last ? '0 : cnt_q + ADDR_W'(1);
                    if (cnt_last) begin
                        state_d = ST_REQ;
`ifdef IDDMM_FEEDER_REUSE_M_EN
                        m_loaded_d = 1'b1;
`endif
                    end
                end
            end
            // task_req rises one cycle after entry, once the last RAM write has landed.
            ST_REQ: begin
                if (task_req_q && task_grant) begin
                    state_d = ST_RUN;
                end else begin
                    task_req_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (task_end) begin
                    buf_we = 1'b1;
                    rcnt_d = (rcnt_q == LAST) ? '0 : rcnt_q + ADDR_W'(1);
                    if (rcnt_q == LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    rptr_d = (rptr_q == LAST) ? '0 : rptr_q + ADDR_W'(1);
                    if (rptr_q == LAST) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD_X) ||
                         (state_d == ST_LOAD_Y) || (state_d == ST_LOAD_M);
    assign unexp_end_d = unexp_end_q | (task_end & (state_q != ST_RUN));
    // Reading at rptr_d keeps out_data aligned with rptr_q without a bubble after each accept.
    assign buf_re      = (state_q == ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            rptr_q      <= '0;
            wr_ena_q    <= 3'b000;
            wr_addr_q   <= '0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_m_q      <= '0;
            wr_m1_q     <= '0;
            task_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            unexp_end_q <= 1'b0;
`ifdef IDDMM_FEEDER_REUSE_M_EN
            m_loaded_q  <= 1'b0;
            reuse_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            rptr_q      <= rptr_d;
            wr_ena_q    <= wr_ena_d;
            wr_addr_q   <= wr_addr_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            wr_m_q      <= wr_m_d;
            wr_m1_q     <= wr_m1_d;
            task_req_q  <= task_req_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            unexp_end_q <= unexp_end_d;
`ifdef IDDMM_FEEDER_REUSE_M_EN
            m_loaded_q  <= m_loaded_d;
            reuse_q     <= reuse_d;
`endif
        end
    end

    iddmm_res_buf #(
        .K      (K),
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_res_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (buf_we),
        .wr_addr_i (rcnt_q),
        .wr_data_i (task_res),
        .rd_en_i   (buf_re),
        .rd_addr_i (rptr_d),
        .rd_data_o (buf_rd_data)
    );

    assign in_ready  = in_ready_q;
    assign wr_ena    = wr_ena_q;
    assign wr_addr   = wr_addr_q;
    assign wr_x      = wr_x_q;
    assign wr_y      = wr_y_q;
    assign wr_m      = wr_m_q;
    assign wr_m1     = wr_m1_q;
    assign task_req  = task_req_q;
    assign out_valid = out_valid_q;
    assign out_data  = buf_rd_data;
    assign out_last  = out_valid_q & (rptr_q == LAST);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iddmm_feeder.sv
// Randomized bench for iddmm_feeder (K=8, N=4) against a queue-based model of the expected RAM writes and result stream.
module tb_iddmm_feeder;

    localparam int K  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    typedef struct packed {
        logic [2:0]    ena;
        logic [AW-1:0] addr;
        logic [K-1:0]  dat;
    } wr_t;

    logic          clk, rst_n;
    logic [K-1:0]  m1_in, in_data, task_res;
    logic          in_valid, in_ready, task_req, task_grant, task_end;
    logic [2:0]    wr_ena;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1, out_data;
    logic          out_valid, out_ready, out_last, busy;
`ifdef IDDMM_FEEDER_REUSE_M_EN
    logic          reuse_m;
    bit            reuse_cfg;
`endif

    int            n_cmp, n_err, n_wr;
    wr_t           exp_wr[$];
    logic [K-1:0]  xw[N], yw[N], mw[N], rw[N];
    logic [K-1:0]  m1v, exp_m1;

    iddmm_feeder #(.K(K), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m1_in      (m1_in),
`ifdef IDDMM_FEEDER_REUSE_M_EN
        .reuse_m    (reuse_m),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_m       (wr_m),
        .wr_m1      (wr_m1),
        .task_req   (task_req),
        .task_grant (task_grant),
        .task_end   (task_end),
        .task_res   (task_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every RAM write must match the next entry of the expected write list.
    always @(negedge clk) begin
        if (rst_n && wr_ena != 3'b000) begin
            wr_t e;
            logic [K-1:0] d;
            n_wr++;
            d = (wr_ena == 3'b001) ? wr_x : (wr_ena == 3'b010) ? wr_y : wr_m;
            if (exp_wr.size() == 0) begin
                chk("wr_extra", 32'(wr_ena), 32'd0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_ena", 32'(wr_ena), 32'(e.ena));
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_dat", 32'(d), 32'(e.dat));
            end
        end
    end

    task automatic rand_words();
        for (int i = 0; i < N; i++) begin
            xw[i] = 8'($urandom);
            yw[i] = 8'($urandom);
            mw[i] = 8'($urandom);
            rw[i] = 8'($urandom);
        end
        m1v = 8'($urandom);
    endtask

    task automatic do_load(input int duty, input bit load_m);
        logic [K-1:0] words[$];
        int idx, guard;
        words = {};
        n_wr  = 0;
        for (int i = 0; i < N; i++) begin
            words.push_back(xw[i]);
            exp_wr.push_back({3'b001, AW'(i), xw[i]});
        end
        for (int i = 0; i < N; i++) begin
            words.push_back(yw[i]);
            exp_wr.push_back({3'b010, AW'(i), yw[i]});
        end
        if (load_m) begin
            for (int i = 0; i < N; i++) begin
                words.push_back(mw[i]);
                exp_wr.push_back({3'b100, AW'(i), mw[i]});
            end
            exp_m1 = m1v;
        end
        idx   = 0;
        guard = 0;
        m1_in = m1v;
`ifdef IDDMM_FEEDER_REUSE_M_EN
        reuse_m = reuse_cfg;
`endif
        while (idx < words.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid = (int'($urandom_range(99)) < duty);
            in_data  = words[idx];
            if (in_valid && in_ready) idx++;
        end
        if (guard >= 2000) chk("load_timeout", 32'(idx), 32'(words.size()));
        @(negedge clk);
        in_valid = 1'b0;
        chk("req_early", 32'(task_req), 32'd0);
        chk("in_rdy_req", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("req_rise", 32'(task_req), 32'd1);
        chk("wr_all", 32'(exp_wr.size()), 32'd0);
        chk("wr_cnt", 32'(n_wr), 32'(load_m ? 3 * N : 2 * N));
        chk("wr_m1", 32'(wr_m1), 32'(exp_m1));
    endtask

    task automatic do_grant(input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("req_hold", 32'(task_req), 32'd1);
            @(negedge clk);
        end
        task_grant = 1'b1;
        @(negedge clk);
        task_grant = 1'b0;
        chk("req_drop", 32'(task_req), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic feed(input int nw, input bit gaps);
        for (int k = 0; k < nw; k++) begin
            if (gaps) repeat ($urandom_range(2)) @(negedge clk);
            task_end = 1'b1;
            task_res = rw[k];
            @(negedge clk);
            task_end = 1'b0;
            task_res = 8'($urandom);
        end
    endtask

    task automatic drain(input int mode);
        int k, cyc;
        chk("ov_early", 32'(out_valid), 32'd0);
        chk("in_rdy_run", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ov_first", 32'(out_valid), 32'd1);
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            out_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(1) == 1);
            chk("ov_hold", 32'(out_valid), 32'd1);
            chk("in_rdy_drain", 32'(in_ready), 32'd0);
            chk("out_data", 32'(out_data), 32'(rw[k]));
            chk("out_last", 32'(out_last), 32'(k == N - 1));
            if (out_valid && out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_cnt", 32'(k), 32'(N));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ov", 32'(out_valid), 32'd0);
    endtask

    task automatic run_task(input int duty, input bit load_m, input int gdly, input int mode);
        do_load(duty, load_m);
        do_grant(gdly);
        feed(N, mode != 0);
        drain(mode);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        exp_wr.delete();
        exp_m1 = '0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_wr = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; m1_in = '0;
        task_grant = 1'b0; task_end = 1'b0; task_res = '0; out_ready = 1'b0;
        exp_m1 = '0;
`ifdef IDDMM_FEEDER_REUSE_M_EN
        reuse_m = 1'b0; reuse_cfg = 1'b0;
`endif
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_req", 32'(task_req), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ena", 32'(wr_ena), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Basic task with fixed operands, grant 5 cycles after request, ready toggling 1010.
        for (int i = 0; i < N; i++) begin
            xw[i] = 8'(i + 1);
            yw[i] = 8'(i + 5);
            mw[i] = 8'(i + 9);
            rw[i] = 8'($urandom);
        end
        m1v = 8'h5a;
        run_task(100, 1'b1, 5, 0);

        // Sparse input valid, random grant delay, gapped results, random out_ready.
        rand_words();
        run_task(30, 1'b1, int'($urandom_range(4)) + 1, 1);

        // Reset halfway through result capture.
        rand_words();
        do_load(100, 1'b1);
        do_grant(2);
        feed(2, 1'b0);
        rst_n = 1'b0;
        exp_wr.delete();
        exp_m1 = '0;
        #1;
        chk("mid_rst_wr_ena", 32'(wr_ena), 32'd0);
        chk("mid_rst_wr_m1", 32'(wr_m1), 32'd0);
        chk("mid_rst_req", 32'(task_req), 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_words();
        run_task(70, 1'b1, 1, 1);

        // Stray task_end while idle.
        chk("flag_clear", 32'(dut.unexp_end_q), 32'd0);
        task_end = 1'b1;
        task_res = 8'($urandom);
        @(negedge clk);
        task_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_ov", 32'(out_valid), 32'd0);
            chk("stray_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        chk("stray_flag", 32'(dut.unexp_end_q), 32'd1);

        for (int t = 0; t < 3; t++) begin
            rand_words();
            run_task(int'($urandom_range(60)) + 40, 1'b1, int'($urandom_range(3)) + 1, 1);
        end

`ifdef IDDMM_FEEDER_REUSE_M_EN
        // After reset no m is loaded yet, so reuse is ignored once and honoured on the next task.
        reset_pulse();
        reuse_cfg = 1'b1;
        rand_words();
        run_task(100, 1'b1, 2, 1);
        rand_words();
        run_task(100, 1'b0, 2, 0);
        reuse_cfg = 1'b0;
        rand_words();
        run_task(50, 1'b1, 1, 1);
`else
        reset_pulse();
        rand_words();
        run_task(100, 1'b1, 2, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
